// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty detection and first-word-fall-through output stage
// for a dual-clock FIFO; also reports a registered fill level and almost-empty.
module rptr_empty_fwft #(
  parameter int unsigned ADDRSIZE  = 6,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDRSIZE:0]     rq2_wptr,
  input  logic                  rinc,
  input  logic [DSIZE-1:0]      mem_rdata,
  output logic [ADDRSIZE-1:0]   raddr,
  output logic [ADDRSIZE:0]     rptr,
  output logic [DSIZE-1:0]      rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic [ADDRSIZE+1:0]   rlevel,
  output logic                  ralmost_empty
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam int unsigned LW = ADDRSIZE + 2;

  logic [PW-1:0]    rbin_q, rbin_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             mem_empty_q, mem_empty_d;
  logic             rvalid_q, rvalid_d;
  logic             rempty_q, rempty_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [LW-1:0]    rlevel_q, rlevel_d;
  logic             ralmost_empty_q, ralmost_empty_d;

  logic             pop;
  logic             fetch;
  logic [PW-1:0]    wbin_s;
  logic [PW-1:0]    diff;

  // Next-state: pointer advance, FWFT register refill and level bookkeeping
  always_comb begin
    pop             = rinc & rvalid_q;
    fetch           = ~mem_empty_q & (~rvalid_q | pop);
    rbin_d          = rbin_q + PW'(fetch);
    rptr_d          = (rbin_d >> 1) ^ rbin_d;
    mem_empty_d     = (rptr_d == rq2_wptr);
    rvalid_d        = rvalid_q;
    rdata_d         = rdata_q;
    if (fetch) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_rdata;
    end else if (pop) begin
      rvalid_d = 1'b0;
    end
    rempty_d        = ~rvalid_d;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    wbin_s          = rq2_wptr;
    for (int i = 1; i < int'(PW); i++) begin
      wbin_s = wbin_s ^ (rq2_wptr >> i);
    end
    diff            = wbin_s - rbin_d;
    rlevel_d        = LW'(diff) + LW'(rvalid_d);
    ralmost_empty_d = (rlevel_d <= LW'(AE_THRESH));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q          <= '0;
      rptr_q          <= '0;
      mem_empty_q     <= 1'b1;
      rvalid_q        <= 1'b0;
      rempty_q        <= 1'b1;
      rdata_q         <= '0;
      rlevel_q        <= '0;
      ralmost_empty_q <= 1'b1;
    end else begin
      rbin_q          <= rbin_d;
      rptr_q          <= rptr_d;
      mem_empty_q     <= mem_empty_d;
      rvalid_q        <= rvalid_d;
      rempty_q        <= rempty_d;
      rdata_q         <= rdata_d;
      rlevel_q        <= rlevel_d;
      ralmost_empty_q <= ralmost_empty_d;
    end
  end

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign rempty        = rempty_q;
  assign rlevel        = rlevel_q;
  assign ralmost_empty = ralmost_empty_q;

endmodule
